// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter sharing one PSRAM data port between
// the CPU data path (m0) and a secondary master (m1). One strobe per access,
// completion on ram_ready, and a watchdog that force-completes stuck accesses.
module ram_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_wen,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_be,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_done,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_wen,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_be,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  m1_done,
  output logic                  m1_err,
  output logic                  ram_ren,
  output logic                  ram_wen,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic [DATA_W/8-1:0]   ram_be,
  input  logic [DATA_W-1:0]     ram_rdata,
  input  logic                  ram_ready,
  output logic [1:0]            gnt
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state;
  state_t             state_nx;
  logic               last_grant;  // 0 = m0 served last, 1 = m1 served last
  logic               owner;       // port owning the current access
  logic               wen_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt;

  logic               grant_go;
  logic               grant_sel;
  logic               rd_ok;
  logic               tmo;

  // Arbitration decision and WAIT exit conditions.
  // cnt is zero only in the first WAIT cycle, where ram_ready is still stale.
  always_comb begin
    grant_go  = ram_ready & (m0_req | m1_req);
    grant_sel = (m0_req & m1_req) ? ~last_grant : m1_req;
    rd_ok     = (cnt != '0) & ram_ready;
    tmo       = (cnt == CNT_W'(TIMEOUT - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; DONE always returns to IDLE so accesses are separated.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant_go) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (rd_ok || tmo) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Command latch, round-robin pointer, watchdog counter and read-data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      wen_q      <= 1'b0;
      err_q      <= 1'b0;
      cnt        <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_be     <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_go) begin
            owner      <= grant_sel;
            last_grant <= grant_sel;
            err_q      <= 1'b0;
            wen_q      <= grant_sel ? m1_wen   : m0_wen;
            ram_addr   <= grant_sel ? m1_addr  : m0_addr;
            ram_wdata  <= grant_sel ? m1_wdata : m0_wdata;
            ram_be     <= grant_sel ? m1_be    : m0_be;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (rd_ok) begin
            if (!wen_q) begin
              if (owner) m1_rdata <= ram_rdata;
              else       m0_rdata <= ram_rdata;
            end
          end else if (tmo) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state: strobes in ISSUE, done/err in DONE, gnt while busy.
  always_comb begin
    ram_ren = (state == ISSUE) & ~wen_q;
    ram_wen = (state == ISSUE) &  wen_q;
    m0_done = (state == DONE) & ~owner;
    m1_done = (state == DONE) &  owner;
    m0_err  = m0_done & err_q;
    m1_err  = m1_done & err_q;
    gnt     = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single PSRAM data port (ramData) between two requesters: m0 is the CPU data path and m1 is a secondary master such as a flash-to-RAM copy engine or the screen fetch path.
- Grants requesters round-robin and latches the winner's command.
- Issues exactly one ram_ren/ram_wen strobe per access, waits for ram_ready, and returns read data with a one-cycle done pulse.
- A watchdog ends any access the RAM never completes.

Parameters:
- ADDR_W, 32, address width on both masters and the RAM side.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT, 1023, max WAIT cycles before forced completion; the counter is clog2(TIMEOUT+1) bits.

Ports:
- clk  in  1  system clock (cpu_clk domain).
- reset  in  1  asynchronous, active-low reset.
- m0_req, m1_req  in  1  access request; held high until the matching done.
- m0_wen, m1_wen  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  ADDR_W  byte address.
- m0_wdata, m1_wdata  in  DATA_W  write data.
- m0_be, m1_be  in  DATA_W/8  byte select.
- m0_rdata, m1_rdata  out  DATA_W  read data, registered per port.
- m0_done, m1_done  out  1  one-cycle completion pulse.
- m0_err, m1_err  out  1  high together with done when the access timed out.
- ram_ren, ram_wen  out  1  one-cycle RAM strobes.
- ram_addr, ram_wdata, ram_be  out  ADDR_W / DATA_W / DATA_W/8  latched command, held stable from ISSUE through DONE.
- ram_rdata  in  DATA_W  RAM read data, valid while ram_ready is high after an access.
- ram_ready  in  1  high = RAM idle / previous access complete.
- gnt  out  2  one-hot current owner; 00 when idle.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE.
  - All outputs 0: rdata regs, done, err, strobes, gnt, ram_addr/wdata/be.
  - last_grant=1, so m0 wins the first tie.
  - Timeout counter 0.
  - Reset asserted mid-access aborts immediately; no done is produced.
- FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - Requests are sampled only when ram_ready=1.
  - One requester asserting wins.
  - Both asserting: the winner is the port not equal to last_grant.
  - On grant: latch wen/addr/wdata/be, set gnt, update last_grant, go to ISSUE.
  - No requests, or ram_ready=0: stay in IDLE.
- ISSUE (exactly 1 cycle): ram_wen=latched wen and ram_ren=~latched wen. Clear the timeout counter, go to WAIT.
- WAIT:
  - The first WAIT cycle ignores ram_ready, because the RAM needs one cycle to deassert it.
  - From the second WAIT cycle on: ram_ready=1 means, for a read, capture ram_rdata into the owner's rdata register, then go to DONE.
  - The counter increments each WAIT cycle. When it reaches TIMEOUT: go to DONE with the err flag set, and leave rdata unchanged.
- DONE (1 cycle): the owner's done=1 and err=flag; gnt is cleared on exit. Next state is IDLE, so at least one idle cycle separates accesses.
- Latency:
  - Request seen at edge k yields the strobe in cycle k+1.
  - Earliest done is cycle k+4 (ram_ready sampled high at k+3).
  - Done comes 1 cycle after the first qualifying ram_ready.
- rdata is held until the next completed read on the same port; writes do not modify rdata.
- A requester dropping req mid-access has no effect: the access completes and done still pulses.
- A requester that keeps req high after done is re-arbitrated in the next IDLE.
  - Under continuous contention the grants alternate m0, m1, m0, ...
- Only the owner's done/err pulse; the other port's outputs stay 0.
- Timeout counter saturation: it never wraps, because WAIT exits at TIMEOUT.

Test Plan:
1. Reset release, m0 read addr 0x0000_0100, RAM returns 0xCAFE_F00D with ram_ready high at the earliest point -> ram_ren pulses one cycle at k+1, m0_done at k+4, m0_rdata=0xCAFE_F00D, gnt=01 during the access.
2. m0 and m1 request in the same cycle, both held for 4 accesses -> grant order m0, m1, m0, m1; exactly one strobe per access; never both done pulses at once.
3. m1 write addr 0x40, wdata 0x1234_5678, be=0011, ram_ready low for 10 cycles -> ram_wen one cycle with ram_addr/wdata/be stable until DONE; m1_done exactly one cycle after ram_ready returns; m1_rdata unchanged.
4. TIMEOUT=15, ram_ready stuck low after the strobe -> m0_done=1 and m0_err=1 after 15 WAIT cycles, FSM returns to IDLE, and the next request is still accepted once ram_ready=1.
5. reset driven low during WAIT of an m1 read -> all outputs 0 immediately, no done pulse; after release m0 wins a tie (last_grant=1).
6. m0 drops req the cycle after ISSUE -> the access still completes and m0_done pulses; m1 requesting meanwhile is granted next.
